rv32i_fetch_stage: RTL and testbench
====================================

RV32I_FETCH_STAGE -- requirements
Module: rv32i_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning fetch buffer entries (power of two, 2..8).
REQ-003 SHALL have clk  input  1  clock: clk, all state on rising edge.
REQ-004 SHALL have reset  input  1  reset: synchronous, active-high.
REQ-005 SHALL have imem_req  output  1  fetch request, valid with imem_addr.
REQ-006 SHALL have imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have imem_rvalid  input  1  response valid for the single outstanding request.
REQ-008 SHALL have imem_rdata  input  32  instruction word returned.
REQ-009 SHALL have jump_en_in  input  1  redirect request from decode.
REQ-010 SHALL have jump_addr_in  input  32  redirect target.
REQ-011 SHALL have pc_halt_in  input  1  decode stall: hold outputs.
REQ-012 SHALL have iw_out  output  32  instruction word to decode.
REQ-013 SHALL have pc_out  output  32  PC of iw_out.
REQ-014 SHALL have jump_en_out  output  1  jump_en_in delayed one cycle, to decode.
REQ-015 SHALL have misalign_fault  output  1  sticky misaligned-redirect flag.

Function
REQ-016 SHALL keep at most one imem request outstanding; FSM states IDLE, WAIT, DROP, HALT.
REQ-017 SHALL, in IDLE, assert imem_req for one cycle with imem_addr=fetch_pc when (fifo_count < FIFO_DEPTH), then go to WAIT; fetch_pc += 4 at that edge.
REQ-018 SHALL, in WAIT, on imem_rvalid push {pc, imem_rdata} into the FIFO and return to IDLE; imem_req may reissue in the following cycle.
REQ-019 SHALL, when pc_halt_in=0: if FIFO non-empty, pop head to iw_out/pc_out; if empty, iw_out<=32'h13, pc_out holds.
REQ-020 SHALL, when pc_halt_in=1, hold iw_out/pc_out and not pop; fetching continues until the FIFO is full.
REQ-021 SHALL make a word accepted at edge E visible on iw_out after edge E+1 at the earliest (no bypass).
REQ-022 SHALL, on jump_en_in=1: flush FIFO, fetch_pc<=jump_addr_in, iw_out<=32'h13, go to DROP if in WAIT without imem_rvalid this cycle, else IDLE.
REQ-023 SHALL, in DROP, discard the next imem_rvalid word and go to IDLE; no request issued in DROP.
REQ-024 SHALL give priority reset > jump_en_in > pc_halt_in > normal flow; a jump during halt is honoured.
REQ-025 SHALL, on simultaneous push and pop, keep fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 SHALL register jump_en_out <= jump_en_in every cycle (0 under reset).

Reset
REQ-027 SHALL, under reset: fetch_pc=RESET_PC, FSM=IDLE, FIFO empty, imem_req=0, imem_addr=0, iw_out=32'h13, pc_out=0, jump_en_out=0, misalign_fault=0.
REQ-028 SHALL, if reset occurs in WAIT, ignore any imem_rvalid in the reset cycle and the first cycle after reset (enter DROP if a request was outstanding).

Configuration
REQ-029 SHALL, with RV32I_FETCH_MISALIGN_TRAP_EN defined, on jump_en_in with jump_addr_in[1:0]!=0 set misalign_fault=1 (sticky until reset), enter HALT, issue no requests, drive iw_out=32'h13.
REQ-030 SHALL, without RV32I_FETCH_MISALIGN_TRAP_EN, force jump_addr_in[1:0] to 2'b00, tie misalign_fault to 0, and omit HALT.

Verification
REQ-031 SHALL cover reset then 1-cycle-latency memory returning 0x00500093 at 0x0 -> iw_out=0x00500093, pc_out=0x0 two edges after rvalid edge; next fetch addr 0x4.
REQ-032 SHALL cover pc_halt_in=1 for 5 cycles with FIFO_DEPTH=2 -> iw_out held, exactly 2 words buffered, imem_req low while full, in-order drain after release.
REQ-033 SHALL cover jump_en_in=1, jump_addr_in=0x100 while WAIT -> in-flight word discarded, iw_out=0x13, next imem_addr=0x100, jump_en_out=1 one cycle later.
REQ-034 SHALL cover jump to 0x102 -> with macro: misalign_fault=1, no further imem_req; without: next imem_addr=0x100.
REQ-035 SHALL cover reset asserted in WAIT with rvalid one cycle later -> word dropped, first fetch at RESET_PC.

Source files
------------

// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction fetch: one outstanding imem request, FIFO_DEPTH-entry buffer, redirect/flush from decode.
// Latency: word returned at edge E appears on iw_out after edge E+1 at the earliest (no bypass path).
// Backpressure: pc_halt_in holds iw_out/pc_out; fetching continues until the buffer is full, then imem_req stays low.
// Optional feature: define RV32I_FETCH_MISALIGN_TRAP_EN to trap misaligned redirects (sticky fault + HALT state).
module rv32i_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        jump_en_in,
    input  logic [31:0] jump_addr_in,
    input  logic        pc_halt_in,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic        jump_en_out,
    output logic        misalign_fault
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2, HALT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;
`endif

    state_t        state;
    state_t        drain_state;
    state_t        jump_state;
    logic [31:0]   fetch_pc;
    logic [31:0]   jump_target;
    logic [31:0]   fifo_iw [FIFO_DEPTH];
    logic [31:0]   fifo_pc [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    // Next-state helpers: an unanswered request forces DROP so its late response is discarded
    always_comb begin
        jump_target = jump_addr_in & 32'hFFFF_FFFC;
        if ((state == WAIT || state == DROP) && !imem_rvalid) begin
            drain_state = DROP;
        end else begin
            drain_state = IDLE;
        end
        jump_state = drain_state;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        if ((jump_addr_in[1:0] != 2'b00) || state == HALT) begin
            jump_state = HALT;
        end
`endif
        push = (state == WAIT) && imem_rvalid && !jump_en_in;
        pop  = !pc_halt_in && (count != '0) && !jump_en_in;
    end

    // Buffer storage: written only on an accepted response, tagged with the request address
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_iw[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr] <= imem_addr;
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk) begin
        if (reset || jump_en_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Fetch FSM with registered request and decode-facing outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= drain_state;
            fetch_pc    <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0;
            iw_out      <= NOP;
            pc_out      <= 32'h0;
            jump_en_out <= 1'b0;
        end else begin
            jump_en_out <= jump_en_in;
            imem_req    <= 1'b0;
            if (jump_en_in) begin
                state    <= jump_state;
                fetch_pc <= jump_target;
                iw_out   <= NOP;
            end else begin
                case (state)
                    IDLE: begin
                        if (count < DEPTH_C) begin
                            imem_req  <= 1'b1;
                            imem_addr <= fetch_pc;
                            fetch_pc  <= fetch_pc + 32'd4;
                            state     <= WAIT;
                        end
                    end
                    WAIT: if (imem_rvalid) state <= IDLE;
                    DROP: if (imem_rvalid) state <= IDLE;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
                    HALT: state <= HALT;
`endif
                    default: state <= IDLE;
                endcase
                if (pop) begin
                    iw_out <= fifo_iw[rd_ptr];
                    pc_out <= fifo_pc[rd_ptr];
                end else if (!pc_halt_in) begin
                    iw_out <= NOP;
                end
            end
        end
    end

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    // Sticky fault: set by a misaligned redirect, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_fault <= 1'b0;
        end else if (jump_en_in && (jump_addr_in[1:0] != 2'b00)) begin
            misalign_fault <= 1'b1;
        end
    end
`else
    assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Directed bench for rv32i_fetch_stage: 1-cycle-latency memory responder, per-scenario tasks with inline checks.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Build with or without RV32I_FETCH_MISALIGN_TRAP_EN; the misalign scenario follows the same macro.
module tb_rv32i_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        jump_en_in;
    logic [31:0] jump_addr_in;
    logic        pc_halt_in;
    logic [31:0] iw_out;
    logic [31:0] pc_out;
    logic        jump_en_out;
    logic        misalign_fault;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    logic        pend;
    logic [31:0] pend_addr;

    always #5 clk = ~clk;

    rv32i_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .jump_en_in     (jump_en_in),
        .jump_addr_in   (jump_addr_in),
        .pc_halt_in     (pc_halt_in),
        .iw_out         (iw_out),
        .pc_out         (pc_out),
        .jump_en_out    (jump_en_out),
        .misalign_fault (misalign_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return 32'hC0DE_0000 | a;
    endfunction

    // Memory: a request seen in one cycle is answered in the next cycle
    initial begin
        logic had_pend;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend        = 1'b0;
        pend_addr   = 32'h0;
        forever begin
            @(negedge clk);
            had_pend    = pend;
            imem_rvalid = 1'b0;
            if (pend) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end
            if (imem_req === 1'b1) begin
                if (had_pend) viol++;
                pend      = 1'b1;
                pend_addr = imem_addr;
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        jump_en_in = 1'b0;
        pc_halt_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        total++; if (iw_out !== 32'h13) begin bad++; $display("FAIL rst_iw: got %h want 13", iw_out); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", pc_out); end
        total++; if (jump_en_out !== 1'b0) begin bad++; $display("FAIL rst_jout: got %b want 0", jump_en_out); end
        total++; if (misalign_fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", misalign_fault); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL ff_req0: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        repeat (2) @(negedge clk);
        total++; if (iw_out !== 32'h13) begin bad++; $display("FAIL ff_nobypass: got %h want 13", iw_out); end
        @(negedge clk);
        total++; if (iw_out !== 32'h0050_0093 || pc_out !== 32'h0) begin bad++; $display("FAIL ff_word: got iw=%h pc=%h want 00500093/0", iw_out, pc_out); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL ff_req4: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int seen;
        do_reset();
        exp_pc = 32'h0;
        seen   = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (iw_out !== 32'h13) begin
                total++;
                if (iw_out !== mem_word(exp_pc) || pc_out !== exp_pc) begin
                    bad++; $display("FAIL stream_order: got iw=%h pc=%h want %h/%h", iw_out, pc_out, mem_word(exp_pc), exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
        end
        total++; if (seen < 8) begin bad++; $display("FAIL stream_count: got %0d words want >= 8", seen); end
    endtask

    task automatic test_halt();
        int nreq;
        do_reset();
        pc_halt_in = 1'b1;
        nreq = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) nreq++;
            total++; if (iw_out !== 32'h13) begin bad++; $display("FAIL halt_hold: cycle %0d got %h want 13", i, iw_out); end
            if (i >= 6) begin
                total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_full_req: cycle %0d got %b want 0", i, imem_req); end
            end
        end
        total++; if (nreq != 2) begin bad++; $display("FAIL halt_nreq: got %0d want 2", nreq); end
        pc_halt_in = 1'b0;
        @(negedge clk);
        total++; if (iw_out !== mem_word(32'h0) || pc_out !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL halt_drain0: got iw=%h pc=%h req=%b", iw_out, pc_out, imem_req); end
        @(negedge clk);
        total++; if (iw_out !== mem_word(32'h4) || pc_out !== 32'h4) begin bad++; $display("FAIL halt_drain1: got iw=%h pc=%h want %h/4", iw_out, pc_out, mem_word(32'h4)); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL halt_refetch: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
        @(negedge clk);
        total++; if (iw_out !== 32'h13 || pc_out !== 32'h4) begin bad++; $display("FAIL halt_empty: got iw=%h pc=%h want 13/4", iw_out, pc_out); end
        repeat (2) @(negedge clk);
        total++; if (iw_out !== mem_word(32'h8) || pc_out !== 32'h8) begin bad++; $display("FAIL halt_next: got iw=%h pc=%h want %h/8", iw_out, pc_out, mem_word(32'h8)); end
    endtask

    task automatic test_jump();
        do_reset();
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || jump_en_out !== 1'b0) begin bad++; $display("FAIL jmp_pre: got req=%b jout=%b want 1/0", imem_req, jump_en_out); end
        jump_en_in   = 1'b1;
        jump_addr_in = 32'h100;
        @(negedge clk);
        jump_en_in = 1'b0;
        total++; if (jump_en_out !== 1'b1) begin bad++; $display("FAIL jmp_jout: got %b want 1", jump_en_out); end
        total++; if (iw_out !== 32'h13 || imem_req !== 1'b0) begin bad++; $display("FAIL jmp_flush: got iw=%h req=%b want 13/0", iw_out, imem_req); end
        @(negedge clk);
        total++; if (jump_en_out !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL jmp_drop: got jout=%b req=%b want 0/0", jump_en_out, imem_req); end
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL jmp_target: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
        total++; if (iw_out !== 32'h13) begin bad++; $display("FAIL jmp_discard: got %h want 13", iw_out); end
        repeat (3) @(negedge clk);
        total++; if (iw_out !== mem_word(32'h100) || pc_out !== 32'h100) begin bad++; $display("FAIL jmp_word: got iw=%h pc=%h want %h/100", iw_out, pc_out, mem_word(32'h100)); end
    endtask

    task automatic test_misalign();
        do_reset();
        repeat (4) @(negedge clk);
        jump_en_in   = 1'b1;
        jump_addr_in = 32'h102;
        @(negedge clk);
        jump_en_in = 1'b0;
        total++; if (iw_out !== 32'h13 || imem_req !== 1'b0) begin bad++; $display("FAIL mis_flush: got iw=%h req=%b want 13/0", iw_out, imem_req); end
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        begin
            int nreq;
            nreq = 0;
            total++; if (misalign_fault !== 1'b1) begin bad++; $display("FAIL mis_fault: got %b want 1", misalign_fault); end
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (imem_req === 1'b1) nreq++;
            end
            total++; if (nreq != 0) begin bad++; $display("FAIL mis_noreq: got %0d requests want 0", nreq); end
            total++; if (misalign_fault !== 1'b1 || iw_out !== 32'h13) begin bad++; $display("FAIL mis_sticky: got fault=%b iw=%h want 1/13", misalign_fault, iw_out); end
        end
`else
        total++; if (misalign_fault !== 1'b0) begin bad++; $display("FAIL mis_fault: got %b want 0", misalign_fault); end
        repeat (2) @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL mis_align: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
`endif
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        repeat (4) @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL rw_pre: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (imem_req !== 1'b0 || iw_out !== 32'h13 || pc_out !== 32'h0) begin bad++; $display("FAIL rw_rst: got req=%b iw=%h pc=%h want 0/13/0", imem_req, iw_out, pc_out); end
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rw_drop: got req=%b want 0", imem_req); end
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rw_refetch: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        repeat (2) @(negedge clk);
        total++; if (iw_out !== 32'h13) begin bad++; $display("FAIL rw_discard: got %h want 13", iw_out); end
        @(negedge clk);
        total++; if (iw_out !== mem_word(32'h0) || pc_out !== 32'h0) begin bad++; $display("FAIL rw_word: got iw=%h pc=%h want %h/0", iw_out, pc_out, mem_word(32'h0)); end
    endtask

    initial begin
        reset        = 1'b1;
        jump_en_in   = 1'b0;
        jump_addr_in = 32'h0;
        pc_halt_in   = 1'b0;
        test_reset();
        test_first_fetch();
        test_stream();
        test_halt();
        test_jump();
        test_misalign();
        test_reset_in_wait();
        total++; if (viol != 0) begin bad++; $display("FAIL one_outstanding: got %0d overlapping requests want 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
